// File: rtl/hbridge_multi.sv
// hbridge_multi: NCH-channel H-bridge PWM, shared period counter,
// fractional duty dither, per-leg dead time. Option: HBRIDGE_FAULT_EN.
module hbridge_multi #(
    parameter int DWID = 8,
    parameter int NCH  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  logic [DWID-1:0]     i_period,
    input  logic [DWID-1:0]     i_dead_time,
    input  logic [NCH-1:0]      i_pn,
    input  logic [NCH*DWID-1:0] i_hi_time,
    input  logic [NCH*DWID-1:0] i_hi_frac,
`ifdef HBRIDGE_FAULT_EN
    input  logic                i_fault,
    input  logic                i_fault_clr,
    output logic                o_fault,
`endif
    output logic [NCH-1:0]      o_q_tl,
    output logic [NCH-1:0]      o_q_bl,
    output logic [NCH-1:0]      o_q_tr,
    output logic [NCH-1:0]      o_q_br,
    output logic                o_period_start
);
    localparam int NLEG = 2 * NCH;

    typedef enum logic [1:0] {
        S_OFF,
        S_DEAD,
        S_HI,
        S_LO
    } leg_t;

    logic                     run_q, run_d;
    logic [DWID-1:0]          cnt_q, cnt_d;
    logic [DWID-1:0]          per_q, per_d;
    logic [DWID-1:0]          dead_q, dead_d;
    logic [NCH-1:0]           pn_q, pn_d;
    logic [NCH-1:0][DWID-1:0] acc_q, acc_d;
    logic [NCH-1:0][DWID:0]   hi_q, hi_d;
    leg_t                     st_q [NLEG];
    leg_t                     st_d [NLEG];
    logic [DWID-1:0]          dcnt_q [NLEG];
    logic [DWID-1:0]          dcnt_d [NLEG];

    logic            run;
    logic            per_zero;
    logic            last;
    logic            kill;
    logic            flt;
    logic [DWID-1:0] dead_ld;
    logic [NCH-1:0]  tgt;
    logic [NLEG-1:0] ltgt;

`ifdef HBRIDGE_FAULT_EN
    logic fault_q, fault_d;

    // fault latch; a new fault beats a simultaneous clear
    always_comb begin
        fault_d = fault_q;
        if (i_fault) begin
            fault_d = 1'b1;
        end else if (i_fault_clr) begin
            fault_d = 1'b0;
        end
    end

    assign flt     = i_fault | fault_q;
    assign o_fault = fault_q;
`else
    assign flt = 1'b0;
`endif

    assign run      = run_q & i_enable;
    assign per_zero = (per_q == '0);
    assign last     = (({1'b0, cnt_q} + (DWID+1)'(1)) == {1'b0, per_q});
    assign kill     = ~run | per_zero | flt;
    assign dead_ld  = (dead_q == '0) ? DWID'(1) : dead_q;

    // period counter, shadow load and dither accumulators
    always_comb begin
        logic [DWID:0] sum;
        logic          load;
        run_d  = run_q;
        cnt_d  = cnt_q;
        per_d  = per_q;
        dead_d = dead_q;
        pn_d   = pn_q;
        acc_d  = acc_q;
        hi_d   = hi_q;
        sum    = '0;
        load   = 1'b0;
        if (!i_enable) begin
            run_d = 1'b0;
            cnt_d = '0;
            acc_d = '0;
        end else begin
            run_d = 1'b1;
            if (!run_q || per_zero || last) begin
                load  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DWID'(1);
            end
        end
        if (load) begin
            per_d  = i_period;
            dead_d = i_dead_time;
            pn_d   = i_pn;
            for (int k = 0; k < NCH; k++) begin
                sum = {1'b0, acc_q[k]}
                    + {1'b0, i_hi_frac[k*DWID +: DWID]};
                acc_d[k] = (i_period == '0) ? '0 : sum[DWID-1:0];
                hi_d[k]  = {1'b0, i_hi_time[k*DWID +: DWID]}
                         + {{DWID{1'b0}}, sum[DWID]};
            end
        end
    end

    // per-leg targets: left follows pwm when pn=1, right is its complement
    always_comb begin
        tgt  = '0;
        ltgt = '0;
        for (int k = 0; k < NCH; k++) begin
            tgt[k] = run & ~per_zero & ({1'b0, cnt_q} < hi_q[k]);
            ltgt[k] = pn_q[k] ? tgt[k] : ~tgt[k];
            ltgt[NCH+k] = ~ltgt[k];
        end
    end

    // leg FSMs: every change of conducting gate passes through DEAD
    always_comb begin
        for (int l = 0; l < NLEG; l++) begin
            st_d[l]   = st_q[l];
            dcnt_d[l] = dcnt_q[l];
            if (kill) begin
                st_d[l] = S_OFF;
            end else begin
                unique case (st_q[l])
                    S_OFF: begin
                        st_d[l]   = S_DEAD;
                        dcnt_d[l] = dead_ld;
                    end
                    S_DEAD: begin
                        if (dcnt_q[l] == DWID'(1)) begin
                            st_d[l] = ltgt[l] ? S_HI : S_LO;
                        end else begin
                            dcnt_d[l] = dcnt_q[l] - DWID'(1);
                        end
                    end
                    S_HI: begin
                        if (!ltgt[l]) begin
                            st_d[l]   = S_DEAD;
                            dcnt_d[l] = dead_ld;
                        end
                    end
                    S_LO: begin
                        if (ltgt[l]) begin
                            st_d[l]   = S_DEAD;
                            dcnt_d[l] = dead_ld;
                        end
                    end
                    default: st_d[l] = S_OFF;
                endcase
            end
        end
    end

    // gate decode from registered leg state
    always_comb begin
        o_q_tl = '0;
        o_q_bl = '0;
        o_q_tr = '0;
        o_q_br = '0;
        for (int k = 0; k < NCH; k++) begin
            o_q_tl[k] = (st_q[k] == S_HI);
            o_q_bl[k] = (st_q[k] == S_LO);
            o_q_tr[k] = (st_q[NCH+k] == S_HI);
            o_q_br[k] = (st_q[NCH+k] == S_LO);
        end
    end

    assign o_period_start = run & ~per_zero & (cnt_q == '0);

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            per_q  <= '0;
            dead_q <= '0;
            pn_q   <= '0;
            acc_q  <= '0;
            hi_q   <= '0;
            for (int l = 0; l < NLEG; l++) begin
                st_q[l]   <= S_OFF;
                dcnt_q[l] <= '0;
            end
`ifdef HBRIDGE_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            dead_q <= dead_d;
            pn_q   <= pn_d;
            acc_q  <= acc_d;
            hi_q   <= hi_d;
            for (int l = 0; l < NLEG; l++) begin
                st_q[l]   <= st_d[l];
                dcnt_q[l] <= dcnt_d[l];
            end
`ifdef HBRIDGE_FAULT_EN
            fault_q <= fault_d;
`endif
        end
    end

endmodule

// File: tb/tb_hbridge_multi.sv
// tb_hbridge_multi: behavioural model comparison plus directed checks
// Also exercises the fault latch when HBRIDGE_FAULT_EN is defined.
module tb_hbridge_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  per = '0;
    logic [7:0]  dt = '0;
    logic [1:0]  pn = '0;
    logic [15:0] hi = '0;
    logic [15:0] fr = '0;
    logic [1:0]  tl, bl, tr, br;
    logic        ps;
`ifdef HBRIDGE_FAULT_EN
    logic        flt_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        ofl;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hbridge_multi #(.DWID(8), .NCH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (en),
        .i_period      (per),
        .i_dead_time   (dt),
        .i_pn          (pn),
        .i_hi_time     (hi),
        .i_hi_frac     (fr),
`ifdef HBRIDGE_FAULT_EN
        .i_fault       (flt_i),
        .i_fault_clr   (clr_i),
        .o_fault       (ofl),
`endif
        .o_q_tl        (tl),
        .o_q_bl        (bl),
        .o_q_tr        (tr),
        .o_q_br        (br),
        .o_period_start(ps)
    );

    // behavioural model state (mode: 0 off, 1 gap, 2 driving)
    int m_run, m_cnt, m_per, m_dead, m_fault;
    int m_pn [2];
    int m_hieff [2];
    int m_acc [2];
    int m_mode [4];
    int m_gap [4];
    int m_top [4];

    // monitors
    int runs[$];
    int gaps[$];
    int rl;
    logic p_tl0;
    int offlen [4];
    int dropped [4];
    int prev_on [4];

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        runs.delete();
        gaps.delete();
        rl = 0;
        for (int l = 0; l < 4; l++) dropped[l] = 0;
    endtask

    task automatic model_step();
        int tg [4];
        int run, kill, gl, t, left, s;
        if (rst) begin
            m_run = 0; m_cnt = 0; m_per = 0; m_dead = 0; m_fault = 0;
            for (int k = 0; k < 2; k++) begin
                m_pn[k] = 0; m_hieff[k] = 0; m_acc[k] = 0;
            end
            for (int l = 0; l < 4; l++) begin
                m_mode[l] = 0; m_gap[l] = 0; m_top[l] = 0;
            end
            return;
        end
        run = (m_run != 0 && en) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            t = (run != 0 && m_per != 0 && m_cnt < m_hieff[k]) ? 1 : 0;
            left = (m_pn[k] != 0) ? t : 1 - t;
            tg[k] = left;
            tg[k+2] = 1 - left;
        end
        kill = (run == 0 || m_per == 0) ? 1 : 0;
`ifdef HBRIDGE_FAULT_EN
        if (flt_i || m_fault != 0) kill = 1;
        if (flt_i) m_fault = 1;
        else if (clr_i) m_fault = 0;
`endif
        gl = (m_dead == 0) ? 1 : m_dead;
        for (int l = 0; l < 4; l++) begin
            if (kill != 0) begin
                m_mode[l] = 0;
            end else if (m_mode[l] == 0) begin
                m_mode[l] = 1; m_gap[l] = gl;
            end else if (m_mode[l] == 1) begin
                if (m_gap[l] == 1) begin
                    m_mode[l] = 2; m_top[l] = tg[l];
                end else begin
                    m_gap[l]--;
                end
            end else if (m_top[l] != tg[l]) begin
                m_mode[l] = 1; m_gap[l] = gl;
            end
        end
        if (!en) begin
            m_run = 0; m_cnt = 0; m_acc[0] = 0; m_acc[1] = 0;
        end else if (m_run == 0 || m_per == 0 || m_cnt == m_per - 1) begin
            m_run = 1; m_cnt = 0;
            m_per = per; m_dead = dt;
            for (int k = 0; k < 2; k++) begin
                m_pn[k] = pn[k];
                s = m_acc[k] + fr[k*8 +: 8];
                m_hieff[k] = hi[k*8 +: 8] + s / 256;
                m_acc[k] = (per == 0) ? 0 : s % 256;
            end
        end else begin
            m_cnt++;
        end
    endtask

    task automatic tick();
        logic [1:0] etl, ebl, etr, ebr;
        logic [3:0] tp, bt;
        int eps, on;
        model_step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            etl[k] = (m_mode[k] == 2 && m_top[k] == 1);
            ebl[k] = (m_mode[k] == 2 && m_top[k] == 0);
            etr[k] = (m_mode[k+2] == 2 && m_top[k+2] == 1);
            ebr[k] = (m_mode[k+2] == 2 && m_top[k+2] == 0);
        end
        eps = (m_run != 0 && en && m_per != 0 && m_cnt == 0) ? 1 : 0;
        chk("gates", int'({tl, bl, tr, br}), int'({etl, ebl, etr, ebr}));
        chk("pstart", int'(ps), eps);
`ifdef HBRIDGE_FAULT_EN
        chk("fault", int'(ofl), m_fault);
`endif
        chk("overlap", int'((tl & bl) | (tr & br)), 0);
        if (tl[0]) rl++;
        else if (p_tl0) begin
            runs.push_back(rl);
            rl = 0;
        end
        p_tl0 = tl[0];
        tp = {tr, tl};
        bt = {br, bl};
        for (int l = 0; l < 4; l++) begin
            on = (tp[l] | bt[l]) ? 1 : 0;
            if (on == 0) begin
                if (prev_on[l] != 0) begin
                    dropped[l] = 1;
                    offlen[l] = 0;
                end
                offlen[l]++;
            end else begin
                if (prev_on[l] == 0 && dropped[l] != 0)
                    gaps.push_back(offlen[l]);
                dropped[l] = 0;
            end
            prev_on[l] = on;
        end
    endtask

    initial begin
        int e1 [6];
        int sum, seen, n;
        e1 = '{39, 40, 40, 39, 40, 40};
        p_tl0 = 1'b0;
        for (int l = 0; l < 4; l++) begin
            prev_on[l] = 0; offlen[l] = 0;
        end
        clear_mon();

        rst = 1'b1;
        tick();
        tick();
        chk("rst_gates", int'({tl, bl, tr, br}), 0);
        chk("rst_pstart", int'(ps), 0);

        // dithered duty 40 + 171/256
        rst = 1'b0;
        per = 8'd100; dt = 8'd1; pn = 2'b11;
        hi = {8'd40, 8'd40}; fr = {8'd171, 8'd171};
        clear_mon();
        en = 1'b1;
        repeat (1010) tick();
        chk("t1_nruns", (runs.size() >= 9) ? 1 : 0, 1);
        if (runs.size() >= 9) begin
            for (int i = 0; i < 6; i++) chk("t1_run", runs[i], e1[i]);
            sum = 0;
            for (int i = 0; i < 9; i++) sum += runs[i] + 1;
            chk("t1_sum9", sum, 366);
        end

        // dead time 3, randomized duty, no overlap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        per = 8'd37; dt = 8'd3; pn = 2'($urandom);
        clear_mon();
        for (int b = 0; b < 20; b++) begin
            hi = {8'($urandom_range(2, 30)), 8'($urandom_range(2, 30))};
            fr = 16'($urandom);
            repeat (500) tick();
        end
        chk("t2_ngaps", (gaps.size() > 100) ? 1 : 0, 1);
        foreach (gaps[i]) chk("t2_gap", gaps[i], 3);

        // hi_time change mid-period applies next period
        rst = 1'b1;
        tick();
        rst = 1'b0;
        per = 8'd100; dt = 8'd1; pn = 2'b11;
        hi = {8'd40, 8'd40}; fr = '0;
        clear_mon();
        seen = 0;
        n = 0;
        while (seen < 2 && n < 400) begin
            tick();
            n++;
            if (ps) seen++;
        end
        chk("t3_starts", seen, 2);
        repeat (20) tick();
        hi = {8'd60, 8'd60};
        repeat (250) tick();
        chk("t3_nruns", (runs.size() >= 3) ? 1 : 0, 1);
        if (runs.size() >= 3) begin
            chk("t3_run_p1", runs[0], 39);
            chk("t3_run_p2", runs[1], 39);
            chk("t3_run_p3", runs[2], 59);
        end

        // 0% and 100% duty, polarity swap
        hi = {8'd0, 8'd0};
        repeat (250) tick();
        chk("t4_hi0", int'({tl, bl, tr, br}), int'(8'b00_11_11_00));
        hi = {8'd120, 8'd120};
        repeat (250) tick();
        chk("t4_hi120", int'({tl, bl, tr, br}), int'(8'b11_00_00_11));
        repeat (37) tick();
        pn = 2'b00;
        repeat (250) tick();
        chk("t4_pn0", int'({tl, bl, tr, br}), int'(8'b00_11_11_00));

        // enable drop mid-dead, re-enable gap, reset mid-run
        en = 1'b0;
        tick();
        per = 8'd50; dt = 8'd3; pn = 2'b11;
        hi = {8'd20, 8'd20};
        en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        tick();
        chk("t5_off", int'({tl, bl, tr, br}), 0);
        en = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while ({tl, bl, tr, br} == '0 && n < 50);
        chk("t5_regap", n, 5);
        repeat (100) tick();
        chk("t5_running", ({tl, bl, tr, br} != '0) ? 1 : 0, 1);
        rst = 1'b1;
        tick();
        chk("t5_rst", int'({tl, bl, tr, br, ps}), 0);
        rst = 1'b0;

`ifdef HBRIDGE_FAULT_EN
        repeat (100) tick();
        flt_i = 1'b1;
        tick();
        flt_i = 1'b0;
        chk("t6_gates", int'({tl, bl, tr, br}), 0);
        chk("t6_latch", int'(ofl), 1);
        repeat (20) tick();
        flt_i = 1'b1; clr_i = 1'b1;
        tick();
        flt_i = 1'b0; clr_i = 1'b0;
        chk("t6_both", int'(ofl), 1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("t6_clr", int'(ofl), 0);
        repeat (50) tick();
`endif

        // random soak against the model
        for (int c = 0; c < 8000; c++) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 49) == 0) begin
                per = 8'($urandom_range(0, 12));
                dt = 8'($urandom_range(0, 4));
                hi = {8'($urandom_range(0, 14)), 8'($urandom_range(0, 14))};
                fr = 16'($urandom);
                pn = 2'($urandom);
            end
`ifdef HBRIDGE_FAULT_EN
            flt_i = ($urandom_range(0, 299) == 0);
            clr_i = ($urandom_range(0, 19) == 0);
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
